// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer limits and Gray/binary helpers
// used by both the read-side and write-side pointer controllers.
package fifo_pkg;

    localparam int FIFO_MAX_AW = 16;

    typedef logic [FIFO_MAX_AW:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = '0;
        b[FIFO_MAX_AW] = g[FIFO_MAX_AW];
        for (int i = FIFO_MAX_AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int width = 9
) (
    input  logic [width-1:0] gray,
    output logic [width-1:0] bin
);

    for (genvar i = 0; i < width; i++) begin : g_bit
        assign bin[i] = ^gray[width-1:i];
    end

endmodule

// File: rtl/rptr_level_ctrl.sv
// Read-domain pointer and flag controller for the dual-clock FIFO:
// read address, Gray pointer, empty, level, almost-empty, valid, underflow.
module rptr_level_ctrl
    import fifo_pkg::*;
#(
    parameter int add_size = 8
) (
    input  logic                rd_clk,
    input  logic                rd_rst,
    input  logic                rd_inc,
    input  logic [add_size:0]   wr_ptr_sync,
    input  logic [add_size:0]   aempty_lvl,
    input  logic                uflow_clr,
    output logic [add_size-1:0] rd_addr,
    output logic [add_size:0]   rd_ptr,
    output logic                empty,
    output logic                almost_empty,
    output logic [add_size:0]   rd_level,
    output logic                rd_valid,
    output logic                underflow
);

    localparam int PW = add_size + 1;

    if (add_size < 2 || add_size > FIFO_MAX_AW) begin : g_bad_size
        $error("rptr_level_ctrl: add_size out of range");
    end

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;
    logic          accept;

    gray2bin #(
        .width(PW)
    ) u_wr_g2b (
        .gray(wr_ptr_sync),
        .bin (wbin)
    );

    // Next-state pointer and level; requests while empty are dropped.
    always_comb begin
        accept     = rd_inc & ~empty;
        rbin_next  = rbin + PW'(accept);
        rgray_next = (rbin_next >> 1) ^ rbin_next;
        level_next = wbin - rbin_next;
    end

    assign rd_addr = rbin[add_size-1:0];

    // Pointer, flag and level registers; underflow set beats clear.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rbin         <= '0;
            rd_ptr       <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            rd_valid     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rd_ptr       <= rgray_next;
            empty        <= (rgray_next == wr_ptr_sync);
            almost_empty <= (level_next <= aempty_lvl);
            rd_level     <= level_next;
            rd_valid     <= accept;
            if (rd_inc & empty) begin
                underflow <= 1'b1;
            end else if (uflow_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
